// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - mnemonic, opcode/funct and format definitions for the instruction encoder
package instr_pkg;

    typedef enum logic [5:0] {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR,
        M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_SLTI, M_SLTIU,
        M_LW, M_SW, M_LB, M_LBU, M_SB, M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BGEZ, M_BLTZ,
        M_J, M_JAL
    } mnem_e;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} enc_state_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/instr_fmt.sv
// rtl/instr_fmt.sv - combinational mnemonic+operands to 32-bit instruction word
module instr_fmt
    import instr_pkg::*;
(
    input  logic [5:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        valid,
    output logic [31:0] word
);

    fmt_e       fmt;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] rd_e;
    logic [4:0] sh_e;

    // Select format/opcode/funct and zero the fields each instruction ignores
    always_comb begin
        valid = 1'b1;
        fmt   = FMT_R;
        op    = OP_RTYPE;
        fn    = 6'h00;
        rs_e  = rs;
        rt_e  = rt;
        rd_e  = rd;
        sh_e  = 5'd0;
        case (mnem)
            M_ADD:   fn = FN_ADD;
            M_ADDU:  fn = FN_ADDU;
            M_SUB:   fn = FN_SUB;
            M_SUBU:  fn = FN_SUBU;
            M_AND:   fn = FN_AND;
            M_OR:    fn = FN_OR;
            M_XOR:   fn = FN_XOR;
            M_NOR:   fn = FN_NOR;
            M_SLT:   fn = FN_SLT;
            M_SLTU:  fn = FN_SLTU;
            M_SLL:   begin fn = FN_SLL; rs_e = 5'd0; sh_e = shamt; end
            M_SRL:   begin fn = FN_SRL; rs_e = 5'd0; sh_e = shamt; end
            M_SRA:   begin fn = FN_SRA; rs_e = 5'd0; sh_e = shamt; end
            M_SLLV:  fn = FN_SLLV;
            M_SRLV:  fn = FN_SRLV;
            M_SRAV:  fn = FN_SRAV;
            M_JR:    begin fn = FN_JR; rt_e = 5'd0; rd_e = 5'd0; end
            M_ADDI:  begin fmt = FMT_I; op = OP_ADDI;  end
            M_ADDIU: begin fmt = FMT_I; op = OP_ADDIU; end
            M_ANDI:  begin fmt = FMT_I; op = OP_ANDI;  end
            M_ORI:   begin fmt = FMT_I; op = OP_ORI;   end
            M_XORI:  begin fmt = FMT_I; op = OP_XORI;  end
            M_LUI:   begin fmt = FMT_I; op = OP_LUI;   rs_e = 5'd0; end
            M_SLTI:  begin fmt = FMT_I; op = OP_SLTI;  end
            M_SLTIU: begin fmt = FMT_I; op = OP_SLTIU; end
            M_LW:    begin fmt = FMT_I; op = OP_LW;    end
            M_SW:    begin fmt = FMT_I; op = OP_SW;    end
            M_LB:    begin fmt = FMT_I; op = OP_LB;    end
            M_LBU:   begin fmt = FMT_I; op = OP_LBU;   end
            M_SB:    begin fmt = FMT_I; op = OP_SB;    end
            M_BEQ:   begin fmt = FMT_I; op = OP_BEQ;   end
            M_BNE:   begin fmt = FMT_I; op = OP_BNE;   end
            M_BLEZ:  begin fmt = FMT_I; op = OP_BLEZ;   rt_e = 5'd0; end
            M_BGTZ:  begin fmt = FMT_I; op = OP_BGTZ;   rt_e = 5'd0; end
            M_BGEZ:  begin fmt = FMT_I; op = OP_REGIMM; rt_e = 5'd1; end
            M_BLTZ:  begin fmt = FMT_I; op = OP_REGIMM; rt_e = 5'd0; end
            M_J:     begin fmt = FMT_J; op = OP_J;   end
            M_JAL:   begin fmt = FMT_J; op = OP_JAL; end
            default: valid = 1'b0;
        endcase
    end

    // Pack the selected fields; invalid mnemonics yield an all-zero word
    always_comb begin
        word = 32'd0;
        if (valid) begin
            case (fmt)
                FMT_R:   word = {OP_RTYPE, rs_e, rt_e, rd_e, sh_e, fn};
                FMT_I:   word = {op, rs_e, rt_e, imm};
                default: word = {op, target};
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams encoded instruction words into IMEM through a write port
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [5:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err
);

    enc_state_e  state_q;
    enc_state_e  state_d;
    logic        fmt_valid;
    logic [31:0] fmt_word;
    logic        xfer;
    logic        last_slot;
    logic        restart;

    instr_fmt u_fmt (
        .mnem   (mnem),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .imm    (imm),
        .target (target),
        .valid  (fmt_valid),
        .word   (fmt_word)
    );

    // count never reaches DEPTH while loading, so its low bits are the next address
    assign xfer      = in_valid & in_ready;
    assign last_slot = (count[AW-1:0] == AW'(DEPTH - 1));
    assign restart   = start & (state_q != S_LOAD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: a load ends on an accepted last bundle or when the final slot is written
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (xfer && (in_last || (fmt_valid && last_slot))) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state only, so in_ready never depends on in_valid
    always_comb begin
        in_ready = (state_q == S_LOAD);
        busy     = (state_q == S_LOAD);
        done     = (state_q == S_DONE);
    end

    // Write port, word counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= 32'd0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            we <= 1'b0;
            if (restart) begin
                count <= '0;
                err   <= 1'b0;
            end else if (xfer) begin
                if (fmt_valid) begin
                    we    <= 1'b1;
                    waddr <= count[AW-1:0];
                    wdata <= fmt_word;
                    count <= count + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed scoreboard bench for instr_encoder
module tb_instr_encoder;
    import instr_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, rst4, start, in_valid, in_last;
    logic [5:0]  mnem;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    logic        in_ready, we, busy, done, err;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic [10:0] count;

    logic        in_ready4, we4, busy4, done4, err4;
    logic [1:0]  waddr4;
    logic [31:0] wdata4;
    logic [2:0]  count4;

    wr_t q[$];
    wr_t q4[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .count(count), .err(err)
    );

    instr_encoder #(.DEPTH(4), .AW(2)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_last(in_last), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .we(we4), .waddr(waddr4), .wdata(wdata4),
        .busy(busy4), .done(done4), .count(count4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; every pushed write must appear on exactly the following edge
    task automatic cycle();
        wr_t  e;
        logic exp_we;
        @(posedge clk);
        @(negedge clk);
        exp_we = (q.size() != 0);
        chk("we", 32'(we), 32'(exp_we));
        if (exp_we) begin
            e = q.pop_front();
            if (we) begin
                chk("waddr", 32'(waddr), e.addr);
                chk("wdata", wdata, e.data);
            end
        end
        exp_we = (q4.size() != 0);
        chk("we4", 32'(we4), 32'(exp_we));
        if (exp_we) begin
            e = q4.pop_front();
            if (we4) begin
                chk("waddr4", 32'(waddr4), e.addr);
                chk("wdata4", wdata4, e.data);
            end
        end
    endtask

    task automatic send(input logic [5:0] m, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                        input logic [25:0] tg, input logic last);
        in_valid = 1'b1;
        mnem = m; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
        in_last = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        q.push_back('{addr: a, data: d});
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1; start = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);

        // single add as the whole program
        start = 1'b1; cycle(); start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        send(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        exp_wr(32'd0, 32'h00221820);
        cycle(); idle();
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_done", 32'(done), 32'd1);
        cycle();

        // back-to-back addi, lui(last); done rises with the last write
        start = 1'b1; cycle(); start = 1'b0;
        chk("t2_done_clr", 32'(done), 32'd0);
        chk("t2_count_clr", 32'(count), 32'd0);
        send(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
        exp_wr(32'd0, 32'h20080005);
        cycle();
        send(M_LUI, 5'd3, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
        exp_wr(32'd1, 32'h3C011234);
        cycle();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_count", 32'(count), 32'd2);
        cycle();
        idle();

        // field forcing across formats
        start = 1'b1; cycle(); start = 1'b0;
        send(M_BGEZ, 5'd4, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        exp_wr(32'd0, 32'h0481FFFF); cycle();
        send(M_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100, 1'b0);
        exp_wr(32'd1, 32'h08000100); cycle();
        send(M_SLL, 5'd7, 5'd2, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
        exp_wr(32'd2, 32'h00021100); cycle();
        send(M_JR, 5'd31, 5'd5, 5'd5, 5'd3, 16'h0, 26'h0, 1'b0);
        exp_wr(32'd3, 32'h03E00008); cycle();
        send(M_BLEZ, 5'd3, 5'd9, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0);
        exp_wr(32'd4, 32'h18600010); cycle();
        send(M_SUB, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1'b0);
        exp_wr(32'd5, 32'h00221822); cycle();
        send(M_SW, 5'd29, 5'd4, 5'd7, 5'd1, 16'h0004, 26'h0, 1'b1);
        exp_wr(32'd6, 32'hAFA40004); cycle();
        idle();
        chk("t3_count", 32'(count), 32'd7);
        chk("t3_done", 32'(done), 32'd1);

        // invalid mnemonics: sticky err, no write, no address gap
        start = 1'b1; cycle(); start = 1'b0;
        send(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        exp_wr(32'd0, 32'h00221820); cycle();
        send(6'd50, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
        cycle();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_count_hold", 32'(count), 32'd1);
        send(M_OR, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
        exp_wr(32'd1, 32'h00853025); cycle();
        send(M_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b0);
        exp_wr(32'd2, 32'h0FFFFFFF); cycle();
        chk("t4_err_sticky", 32'(err), 32'd1);
        send(6'd38, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        cycle(); idle();
        chk("t4_done_invalid_last", 32'(done), 32'd1);
        chk("t4_count", 32'(count), 32'd3);
        start = 1'b1; cycle(); start = 1'b0;
        chk("t4_err_clr", 32'(err), 32'd0);
        chk("t4_count_clr", 32'(count), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);

        // memory-full stop on the DEPTH=4 instance
        rst = 1'b1; rst4 = 1'b0;
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        chk("t5_busy4", 32'(busy4), 32'd1);
        for (int i = 0; i < 6; i++) begin
            send(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'(i), 26'h0, 1'b0);
            if (i < 4) q4.push_back('{addr: 32'(i), data: 32'h20080000 | 32'(i)});
            cycle();
        end
        idle();
        chk("t5_done4", 32'(done4), 32'd1);
        chk("t5_count4", 32'(count4), 32'd4);
        chk("t5_in_ready4", 32'(in_ready4), 32'd0);
        chk("t5_err4", 32'(err4), 32'd0);

        // reset mid-load, then restart from address 0
        rst4 = 1'b1; rst = 1'b0;
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        send(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        exp_wr(32'd0, 32'h00221820); cycle();
        send(M_OR, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
        exp_wr(32'd1, 32'h00853025); cycle();
        send(M_SUB, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        send(M_XORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b0);
        cycle();
        idle();
        start = 1'b1; cycle(); start = 1'b0;
        send(M_ADDIU, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0007, 26'h0, 1'b0);
        exp_wr(32'd0, 32'h24220007); cycle();
        idle();
        chk("t6_count_restart", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
